// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the encoder and decoder.
//   CTRL_TOKEN  : 10-bit control tokens indexed by the 2-bit {c1,c0} code.
//   DISP_W      : width of the running-disparity counter (two's complement).
//   tmds_lock_e : decoder lock state.
//   tm_choice   : the encoder's transition-minimising choice for a byte,
//                 returned as q_m[8] (1 = XOR chain, 0 = XNOR chain).
package tmds_pkg;

    localparam int DISP_W = 5;

    localparam logic [9:0] CTRL_TOKEN [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } tmds_lock_e;

    function automatic logic tm_choice(input logic [7:0] data);
        logic [3:0] n1;
        n1 = '0;
        for (int i = 0; i < 8; i++) begin
            n1 = n1 + {3'b000, data[i]};
        end
        return ~((n1 > 4'd4) || ((n1 == 4'd4) && ~data[0]));
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational classification and decode of one aligned 10-bit TMDS symbol.
//   tmds    in  10 : symbol, bit 0 is the first serial bit
//   is_ctrl out 1  : symbol matches one of the four control tokens
//   ctrl    out 2  : control code of the matching token (0 otherwise)
//   data    out 8  : byte recovered from the XOR/XNOR chain
//   ones    out 4  : ones in the un-inverted q_m[7:0]
//   zeros   out 4  : zeros in the un-inverted q_m[7:0]
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] tmds,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [7:0] data,
    output logic [3:0] ones,
    output logic [3:0] zeros
);

    logic [7:0] d;

    always_comb begin
        is_ctrl = 1'b0;
        ctrl    = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (tmds == CTRL_TOKEN[i]) begin
                is_ctrl = 1'b1;
                ctrl    = i[1:0];
            end
        end
    end

    // bit 9 marks that the encoder inverted q_m[7:0] on the wire
    assign d = tmds[9] ? ~tmds[7:0] : tmds[7:0];

    always_comb begin
        data    = '0;
        data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = tmds[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    always_comb begin
        ones = '0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + {3'b000, d[i]};
        end
    end

    assign zeros = 4'd8 - ones;

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: one aligned 10-bit symbol per valid cycle in, decoded
// byte or control code out two cycles later, with disparity/transition checks
// and a control-run based lock detector.
//   clk_in, rst_in          : pixel clock, async active-high reset
//   tmds_in, valid_in       : aligned symbol and its qualifier
//   data_out, control_out   : decoded byte (0 for control) / last control code
//   ve_out, valid_out       : 1 = data symbol / output qualifier
//   disp_err, tm_err        : per-symbol error pulses
//   locked, err_count       : lock state / saturating error count
//
// state    | meaning
// UNLOCKED | counting consecutive control tokens towards lock
// LOCKED   | channel trusted; counting consecutive errored data symbols
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_CTRL = 12,
    parameter int ERR_LIMIT = 4,
    parameter int ERRCNT_W  = 16
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [9:0]          tmds_in,
    input  logic                valid_in,
    output logic [7:0]          data_out,
    output logic [1:0]          control_out,
    output logic                ve_out,
    output logic                valid_out,
    output logic                disp_err,
    output logic                tm_err,
    output logic                locked,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int CRUN_W = $clog2(LOCK_CTRL + 1);
    localparam int ERUN_W = $clog2(ERR_LIMIT + 1);

    logic       dec_is_ctrl;
    logic [1:0] dec_ctrl;
    logic [7:0] dec_data;
    logic [3:0] dec_ones;
    logic [3:0] dec_zeros;

    tmds_symbol_decode u_symbol_decode (
        .tmds    (tmds_in),
        .is_ctrl (dec_is_ctrl),
        .ctrl    (dec_ctrl),
        .data    (dec_data),
        .ones    (dec_ones),
        .zeros   (dec_zeros)
    );

    logic       s1_valid, s1_is_ctrl, s1_t8, s1_t9;
    logic [1:0] s1_ctrl;
    logic [7:0] s1_data;
    logic [3:0] s1_ones, s1_zeros;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_valid   <= 1'b0;
            s1_is_ctrl <= 1'b0;
            s1_t8      <= 1'b0;
            s1_t9      <= 1'b0;
            s1_ctrl    <= '0;
            s1_data    <= '0;
            s1_ones    <= '0;
            s1_zeros   <= '0;
        end else begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_is_ctrl <= dec_is_ctrl;
                s1_t8      <= tmds_in[8];
                s1_t9      <= tmds_in[9];
                s1_ctrl    <= dec_ctrl;
                s1_data    <= dec_data;
                s1_ones    <= dec_ones;
                s1_zeros   <= dec_zeros;
            end
        end
    end

    logic [DISP_W-1:0] cnt, cnt_upd, ones_minus, zeros_minus;
    logic              exp_b9, disp_err_d, tm_err_d, sym_err;

    assign ones_minus  = DISP_W'(s1_ones) - DISP_W'(s1_zeros);
    assign zeros_minus = DISP_W'(s1_zeros) - DISP_W'(s1_ones);

    always_comb begin
        if ((cnt == '0) || (s1_ones == s1_zeros)) begin
            exp_b9 = ~s1_t8;
        end else if ((~cnt[DISP_W-1] && (s1_ones > s1_zeros)) ||
                     (cnt[DISP_W-1] && (s1_zeros > s1_ones))) begin
            exp_b9 = 1'b1;
        end else begin
            exp_b9 = 1'b0;
        end
    end

    // Track the disparity the transmitter actually sent (received bit 9),
    // so a single corrupted bit 9 produces a single error pulse.
    assign cnt_upd = s1_t9 ? (cnt + DISP_W'({s1_t8, 1'b0}) + zeros_minus)
                           : (cnt + ones_minus - DISP_W'({~s1_t8, 1'b0}));

    assign disp_err_d = s1_valid && !s1_is_ctrl && (s1_t9 != exp_b9);
    assign tm_err_d   = s1_valid && !s1_is_ctrl && (s1_t8 != tm_choice(s1_data));
    assign sym_err    = disp_err_d || tm_err_d;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt         <= '0;
            valid_out   <= 1'b0;
            disp_err    <= 1'b0;
            tm_err      <= 1'b0;
            ve_out      <= 1'b0;
            data_out    <= '0;
            control_out <= '0;
            err_count   <= '0;
        end else begin
            valid_out <= s1_valid;
            disp_err  <= disp_err_d;
            tm_err    <= tm_err_d;
            if (s1_valid) begin
                ve_out <= ~s1_is_ctrl;
                if (s1_is_ctrl) begin
                    cnt         <= '0;
                    data_out    <= '0;
                    control_out <= s1_ctrl;
                end else begin
                    cnt      <= cnt_upd;
                    data_out <= s1_data;
                end
            end
            if (sym_err && (err_count != '1)) begin
                err_count <= err_count + ERRCNT_W'(1);
            end
        end
    end

    tmds_lock_e        state, state_nxt;
    logic [CRUN_W-1:0] ctrl_run, ctrl_run_nxt;
    logic [ERUN_W-1:0] err_run, err_run_nxt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= UNLOCKED;
            ctrl_run <= '0;
            err_run  <= '0;
        end else begin
            state    <= state_nxt;
            ctrl_run <= ctrl_run_nxt;
            err_run  <= err_run_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ctrl_run_nxt = ctrl_run;
        err_run_nxt  = err_run;
        if (s1_valid) begin
            case (state)
                UNLOCKED: begin
                    if (!s1_is_ctrl) begin
                        ctrl_run_nxt = '0;
                    end else if (ctrl_run == CRUN_W'(LOCK_CTRL - 1)) begin
                        state_nxt    = LOCKED;
                        ctrl_run_nxt = '0;
                    end else begin
                        ctrl_run_nxt = ctrl_run + CRUN_W'(1);
                    end
                end
                LOCKED: begin
                    if (s1_is_ctrl || !sym_err) begin
                        err_run_nxt = '0;
                    end else if (err_run == ERUN_W'(ERR_LIMIT - 1)) begin
                        state_nxt    = UNLOCKED;
                        err_run_nxt  = '0;
                        ctrl_run_nxt = '0;
                    end else begin
                        err_run_nxt = err_run + ERUN_W'(1);
                    end
                end
                default: state_nxt = UNLOCKED;
            endcase
        end
    end

    assign locked = (state == LOCKED);

endmodule
